uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter D_BIT, default 8: data bits per frame; legal values are 7 and 8.
REQ-002 Parameter SB_TICK, default 16: s_tick count for the stop bit; legal values are 16, 24 and 32.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line; asynchronous to clk; idles high.
REQ-006 s_tick  input  1  one-clk enable pulse at 16x the baud rate.
REQ-007 dout  output  8  last good received byte, right-aligned.
REQ-008 rx_done_tick  output  1  one-clk pulse when dout is updated with a good frame.
REQ-009 frame_err  output  1  one-clk pulse when the stop bit is sampled low.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_sync) before any use; rx_sync resets to 1.
REQ-011 The FSM SHALL have the states idle, start, data and stop, with a 4-bit tick counter s, a 3-bit bit counter n and an 8-bit shift register b.
REQ-012 idle: on rx_sync==0, go to start with s=0; s_tick is not required for this transition.
REQ-013 start: on each s_tick with s==7, if rx_sync==0 go to data with s=0 and n=0, else return to idle (glitch reject, no output pulse); otherwise s increments on s_tick.
REQ-014 data: on each s_tick with s==15, s=0, b={sample,b[7:1]}, and the FSM goes to stop if n==D_BIT-1, else n increments; otherwise s increments on s_tick.
REQ-015 Bit order SHALL be LSB first; on completion dout SHALL be b shifted right by (8-D_BIT), so unused MSBs read 0.
REQ-016 stop: on each s_tick with s==SB_TICK-1, sample rx_sync and go to idle; otherwise s increments on s_tick; s SHALL be wide enough for SB_TICK-1.
REQ-017 A stop sample of 1 SHALL load dout and pulse rx_done_tick in the clk cycle after the final s_tick.
REQ-018 A stop sample of 0 SHALL pulse frame_err instead; dout holds and rx_done_tick stays low.
REQ-019 rx_done_tick and frame_err SHALL never be high together and SHALL never stay high for more than one clk.
REQ-020 Clock cycles without s_tick SHALL leave s, n and b unchanged, except for the idle-to-start transition.
REQ-021 rx activity outside idle SHALL not restart framing; a new frame is recognised only after returning to idle.
REQ-022 A frame whose start bit is low at s==7 SHALL be received in full even if rx later glitches; only the sample points matter.

Reset
REQ-023 On reset the FSM SHALL go to idle, with s, n and b = 0, dout = 8'h00, rx_done_tick = 0, frame_err = 0 and both synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception resumes at the next falling edge.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN selects how each data and stop bit is sampled.
REQ-026 When UART_RX_MAJORITY_EN is defined, each data and stop bit SHALL be the 2-of-3 majority of rx_sync captured on the s_tick cycles at s==13, 14 and 15 (stop: SB_TICK-3..SB_TICK-1).
REQ-027 When UART_RX_MAJORITY_EN is undefined, each data and stop bit SHALL be the single rx_sync value at s==15 (stop: SB_TICK-1), and no vote logic is present.
REQ-028 The start-bit check in REQ-013 SHALL be a single sample at s==7 in both builds.

Verification (s_tick every 4 clk, 16 ticks/bit)
REQ-029 Send frame 0x55 with stop=1, then: one rx_done_tick, dout=0x55, frame_err never high.
REQ-030 Send 0xA3 with the stop bit forced low, then: frame_err pulses once, rx_done_tick stays 0, dout keeps its prior value.
REQ-031 Drive rx low for 3 ticks then high, then: FSM returns to idle with no pulse; a following 0x0F frame gives dout=0x0F.
REQ-032 Assert reset during data bit 4 of 0xFF, then: dout=0x00 and no pulse; a following 0x81 frame gives dout=0x81.
REQ-033 With D_BIT=7, send 0x7F, then: dout=0x7F; back-to-back frames 0x12 then 0x34 give two rx_done_tick pulses.
REQ-034 With UART_RX_MAJORITY_EN defined, flip rx for 1 tick at s==14 of each data bit of 0x3C, then: dout=0x3C.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial-side and result-side signals of the UART receiver.
//   rx           : serial line, idles high (asynchronous to clk)
//   s_tick       : one-clk enable pulse at 16x the baud rate
//   dout         : last good received byte, right-aligned
//   rx_done_tick : one-clk pulse when dout takes a good frame
//   frame_err    : one-clk pulse when the stop bit is sampled low
// master drives the line and tick; slave is the receiver.
interface uart_rx_if;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  modport master (output rx, s_tick, input dout, rx_done_tick, frame_err);
  modport slave  (input rx, s_tick, output dout, rx_done_tick, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (start / D_BIT data LSB first / stop).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : uart_rx_if.slave (rx, s_tick in; dout, rx_done_tick, frame_err out)
// Parameters:
//   D_BIT   : data bits per frame (7 or 8)
//   SB_TICK : s_tick count for the stop bit (16, 24 or 32)
// Build option:
//   UART_RX_MAJORITY_EN : data/stop bits are a 2-of-3 vote of the samples at
//   the last three ticks of the bit; otherwise a single sample at the last tick.
//   The start bit is always a single sample at tick 7.
module uart_rx #(
  parameter int unsigned D_BIT   = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int unsigned    S_W         = $clog2(SB_TICK);
  localparam logic [S_W-1:0] S_START     = S_W'(7);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST      = 3'(D_BIT - 1);
  localparam int unsigned    PAD         = 8 - D_BIT;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_n;
  logic [S_W-1:0] s, s_n;
  logic [2:0]     n, n_n;
  logic [7:0]     b, b_n;
  logic [7:0]     dout_q, dout_n;
  logic           done_q, done_n;
  logic           err_q, err_n;
  logic [1:0]     sync_q;
  logic           rx_sync;
  logic           sample;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.rx};
  end
  assign rx_sync = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [S_W-1:0] S_BIT_V0  = S_W'(13);
  localparam logic [S_W-1:0] S_BIT_V1  = S_W'(14);
  localparam logic [S_W-1:0] S_STOP_V0 = S_W'(SB_TICK - 3);
  localparam logic [S_W-1:0] S_STOP_V1 = S_W'(SB_TICK - 2);

  logic [1:0] vote_q;
  logic       vote_cap;

  // The two earlier samples are held here; the third is rx_sync at the
  // final tick, so the vote resolves in the same cycle as the single sample.
  assign vote_cap = bus.s_tick &&
                    (((state == DATA) && ((s == S_BIT_V0)  || (s == S_BIT_V1))) ||
                     ((state == STOP) && ((s == S_STOP_V0) || (s == S_STOP_V1))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         vote_q <= '0;
    else if (vote_cap) vote_q <= {vote_q[0], rx_sync};
  end

  assign sample = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_sync) | (vote_q[0] & rx_sync);
`else
  assign sample = rx_sync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      s      <= s_n;
      n      <= n_n;
      b      <= b_n;
      dout_q <= dout_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    dout_n  = dout_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s == S_START) begin
            if (!rx_sync) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s == S_BIT_LAST) begin
            s_n = '0;
            b_n = {sample, b[7:1]};
            if (n == N_LAST) state_n = STOP;
            else             n_n     = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s == S_STOP_LAST) begin
            state_n = IDLE;
            if (sample) begin
              done_n = 1'b1;
              // Short frames sit in the top of b; right-align them.
              dout_n = b >> PAD;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- randomized self-checking bench for uart_rx.
// Two receivers (D_BIT=8 and D_BIT=7, SB_TICK=16) share clk, reset and a
// free-running s_tick (every 4 clk). The line is driven one tick period at a
// time; a frame is a list of per-period line levels built from its data.
// The reference model works per frame: good stop -> one rx_done_tick with
// dout = data masked to D_BIT, one clk after the mid-stop tick; bad stop ->
// one frame_err at that point and dout unchanged.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  tcnt = 2'd0;
  int unsigned cyc = 0;
  logic        tick;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    cyc  <= cyc + 1;
  end
  assign tick = (tcnt == 2'd3);

  uart_rx_if bus8 ();
  uart_rx_if bus7 ();

  assign bus8.s_tick = tick;
  assign bus7.s_tick = tick;

  uart_rx #(.D_BIT(8), .SB_TICK(16)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  uart_rx #(.D_BIT(7), .SB_TICK(16)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses, records the cycle of the last one, and
  // checks exclusivity and single-cycle width whenever a pulse is seen.
  int unsigned done8 = 0, err8 = 0, last8 = 0;
  int unsigned done7 = 0, err7 = 0, last7 = 0;
  logic        prev8 = 1'b0, prev7 = 1'b0;

  always @(negedge clk) begin
    if ((bus8.rx_done_tick === 1'b1) || (bus8.frame_err === 1'b1)) begin
      check("excl8", {31'd0, bus8.rx_done_tick & bus8.frame_err}, 0);
      check("width8", {31'd0, prev8}, 0);
      last8 <= cyc;
    end
    if (bus8.rx_done_tick === 1'b1) done8 <= done8 + 1;
    if (bus8.frame_err === 1'b1)    err8  <= err8 + 1;
    prev8 <= (bus8.rx_done_tick === 1'b1) || (bus8.frame_err === 1'b1);

    if ((bus7.rx_done_tick === 1'b1) || (bus7.frame_err === 1'b1)) begin
      check("excl7", {31'd0, bus7.rx_done_tick & bus7.frame_err}, 0);
      check("width7", {31'd0, prev7}, 0);
      last7 <= cyc;
    end
    if (bus7.rx_done_tick === 1'b1) done7 <= done7 + 1;
    if (bus7.frame_err === 1'b1)    err7  <= err7 + 1;
    prev7 <= (bus7.rx_done_tick === 1'b1) || (bus7.frame_err === 1'b1);
  end

  // Model state: expected dout per receiver.
  logic [7:0] exp8 = 8'h00;
  logic [7:0] exp7 = 8'h00;

  // Returns just after the clk edge that sampled s_tick.
  task automatic wait_tick(output int unsigned tc);
    do begin
      @(posedge clk);
      #1;
    end while (tcnt != 2'd0);
    tc = cyc;
  endtask

  task automatic drive_period(input int unsigned which, input logic v, output int unsigned tc);
    if (which == 7) bus7.rx = v;
    else            bus8.rx = v;
    wait_tick(tc);
  endtask

  task automatic idle_periods(input int unsigned which, input int unsigned cnt);
    int unsigned tc;
    for (int unsigned i = 0; i < cnt; i++) drive_period(which, 1'b1, tc);
  endtask

  // Drives one frame, 16 tick periods per bit. flip_off inverts the line for
  // one period at that offset inside every data bit (16 = none). A bad stop
  // is low only through its mid-bit sample, so the line is high again before
  // any start check triggered by the low level.
  task automatic send_frame(input int unsigned which, input logic [7:0] data,
                            input logic stop_ok, input int unsigned flip_off,
                            output int unsigned stop_tc);
    int unsigned tc;
    int unsigned db;
    logic        v;
    db = (which == 7) ? 7 : 8;
    stop_tc = 0;
    for (int unsigned o = 0; o < 16; o++) drive_period(which, 1'b0, tc);
    for (int unsigned i = 0; i < db; i++) begin
      for (int unsigned o = 0; o < 16; o++) begin
        v = data[i];
        if (o == flip_off) v = ~v;
        drive_period(which, v, tc);
      end
    end
    for (int unsigned o = 0; o < 16; o++) begin
      v = stop_ok ? 1'b1 : (o >= 8);
      drive_period(which, v, tc);
      if (o == 7) stop_tc = tc;
    end
  endtask

  task automatic run_frame(input int unsigned which, input logic [7:0] data,
                           input logic stop_ok, input int unsigned flip_off,
                           input string tag);
    int unsigned d0, e0, stc;
    logic [7:0]  got;
    d0 = (which == 7) ? done7 : done8;
    e0 = (which == 7) ? err7  : err8;
    send_frame(which, data, stop_ok, flip_off, stc);
    if (stop_ok) begin
      if (which == 7) exp7 = data & 8'h7F;
      else            exp8 = data;
    end
    got = (which == 7) ? bus7.dout : bus8.dout;
    check($sformatf("%s/done", tag), ((which == 7) ? done7 : done8) - d0, stop_ok ? 1 : 0);
    check($sformatf("%s/ferr", tag), ((which == 7) ? err7 : err8) - e0, stop_ok ? 0 : 1);
    check($sformatf("%s/dout", tag), got, (which == 7) ? exp7 : exp8);
    check($sformatf("%s/lat", tag), (which == 7) ? last7 : last8, stc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tc, d0, e0, which, gap;
    logic [7:0]  data;
    logic        ok;

    bus8.rx = 1'b1;
    bus7.rx = 1'b1;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/dout8", bus8.dout, 8'h00);
    check("rst/dout7", bus7.dout, 8'h00);
    check("rst/done8", bus8.rx_done_tick, 0);
    check("rst/ferr8", bus8.frame_err, 0);
    reset = 1'b0;
    wait_tick(tc);
    idle_periods(8, 2);

    run_frame(8, 8'h55, 1'b1, 16, "f55");
    run_frame(8, 8'hA3, 1'b0, 16, "fA3_badstop");
    idle_periods(8, 4);

    // Short low pulse on the line: rejected at the start check.
    d0 = done8; e0 = err8;
    for (int unsigned i = 0; i < 3; i++) drive_period(8, 1'b0, tc);
    idle_periods(8, 20);
    check("glitch/done", done8 - d0, 0);
    check("glitch/ferr", err8 - e0, 0);
    check("glitch/dout", bus8.dout, exp8);
    run_frame(8, 8'h0F, 1'b1, 16, "f0F");

    // Reset in the middle of data bit 4 of 0xFF.
    d0 = done8; e0 = err8;
    for (int unsigned i = 0; i < 16; i++) drive_period(8, 1'b0, tc);
    for (int unsigned i = 0; i < 4 * 16 + 6; i++) drive_period(8, 1'b1, tc);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp8 = 8'h00;
    exp7 = 8'h00;
    check("midrst/dout8", bus8.dout, exp8);
    check("midrst/dout7", bus7.dout, exp7);
    reset = 1'b0;
    wait_tick(tc);
    idle_periods(8, 20);
    check("midrst/done", done8 - d0, 0);
    check("midrst/ferr", err8 - e0, 0);
    run_frame(8, 8'h81, 1'b1, 16, "f81");

    // Seven-bit receiver, then two frames with no idle gap between them.
    idle_periods(7, 2);
    run_frame(7, 8'h7F, 1'b1, 16, "d7_7F");
    run_frame(7, 8'h12, 1'b1, 16, "d7_12");
    run_frame(7, 8'h34, 1'b1, 16, "d7_34");

    // Line inverted one tick before each data sample point.
    run_frame(8, 8'h3C, 1'b1, 6, "f3C_flip14");
`ifdef UART_RX_MAJORITY_EN
    // Inverted exactly at the last sample tick: outvoted by the two earlier ones.
    run_frame(8, 8'hC5, 1'b1, 7, "fC5_flip15");
`endif

    for (int unsigned k = 0; k < 16; k++) begin
      which = ($urandom_range(0, 2) == 0) ? 7 : 8;
      data  = 8'($urandom);
      ok    = ($urandom_range(0, 4) != 0);
      gap   = $urandom_range(0, 3);
      idle_periods(which, gap);
      run_frame(which, data, ok, 16, $sformatf("rnd%0d", k));
    end

    idle_periods(8, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
